// File: rtl/minterm_scanner.sv
// minterm_scanner
//
// Sweeps an N-bit code from 0 to 2**N-1 and captures the truth table of an
// external combinational function. The code goes out on `code`, and the
// function's answer comes back on `f_in` in the same cycle. Each unpaused
// SCAN cycle stores f_in into truth_table[code] and adds it to a running
// count of ones.
//
// Parameters
//   N            width of the swept code; the table is 2**N bits wide
//
// Ports
//   clk          single clock; all state updates on the rising edge
//   rst_n        synchronous, active-low reset
//   start        begins a sweep; only sampled in IDLE
//   pause        freezes the sweep while high in SCAN; ignored elsewhere
//   f_in         function output for the code currently presented
//   code         code presented to the downstream function block
//   busy         high while the FSM is in SCAN (registered)
//   done         one-cycle pulse while the FSM is in DONE (registered)
//   truth_table  captured table; bit k is f_in sampled while code == k
//   ones         number of 1 bits in truth_table (N+1 bits, cannot overflow)
//
// The table port is named truth_table because `table` is a reserved word
// in SystemVerilog.

module minterm_scanner #(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              f_in,
  output logic [N-1:0]      code,
  output logic              busy,
  output logic              done,
  output logic [2**N-1:0]   truth_table,
  output logic [N:0]        ones
);

  localparam int TW = 2**N;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [N-1:0] CODE_LAST = {N{1'b1}};

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  code_q, code_d;
  logic [TW-1:0] table_q, table_d;
  logic [N:0]    ones_q, ones_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state and datapath logic. The capture uses f_in in the same cycle
  // that code_q is presented, because the external function is purely
  // combinational from code. The last code wraps to zero naturally on the
  // final increment, and the FSM leaves SCAN in that same cycle.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    table_d = table_q;
    ones_d  = ones_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          code_d  = '0;
          table_d = '0;
          ones_d  = '0;
        end
      end

      ST_SCAN: begin
        if (!pause) begin
          table_d[code_q] = f_in;
          ones_d          = ones_q + {{N{1'b0}}, f_in};
          code_d          = code_q + {{(N-1){1'b0}}, 1'b1};
          if (code_q == CODE_LAST) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // busy and done are decoded from the next state and then registered.
  // They therefore match the current state exactly, and the output pins
  // are driven directly by flops.
  always_comb begin
    busy_d = (state_d == ST_SCAN);
    done_d = (state_d == ST_DONE);
  end

  // State registers. Reset takes priority over start, pause and any sweep
  // in progress. A partial table is discarded, and no done pulse follows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      table_q <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      table_q <= table_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign code        = code_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign truth_table = table_q;
  assign ones        = ones_q;

endmodule

// File: doc/minterm_scanner.md
MINTERM_SCANNER -- requirements
Module: minterm_scanner

Interface
REQ-001 The block SHALL have one parameter: N, default 4, the width of the input code; the table width SHALL be 2**N.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: a request to begin a sweep, sampled in IDLE only.
REQ-005 The block SHALL have port pause, input, 1 bit: while high in SCAN, the sweep is frozen.
REQ-006 The block SHALL have port f_in, input, 1 bit: the combinational function output for the current code.
REQ-007 The block SHALL have port code, output, N bits: the code driven to the downstream decoder/function block.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in SCAN.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking sweep completion.
REQ-010 The block SHALL have port table, output, 2**N bits: the captured truth table, with bit k equal to f_in sampled while code==k.
REQ-011 The block SHALL have port ones, output, N+1 bits: the count of 1 bits captured in table.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-013 In IDLE, when start==1, the FSM SHALL move to SCAN on the next edge, with code=0, table=0 and ones=0.
REQ-014 In IDLE, when start==0, the FSM SHALL stay in IDLE, with code, table and ones holding their values.
REQ-015 In SCAN with pause==0, each edge SHALL perform four actions:
  - set table[code] <= f_in;
  - set ones <= ones + f_in;
  - set code <= code + 1;
  - transfer to DONE when code == 2**N-1.
REQ-016 Because f_in is combinational from code, f_in SHALL be sampled in the same cycle that code is presented, with zero added latency.
REQ-017 In SCAN with pause==1, code, table and ones SHALL hold, and no capture SHALL occur.
REQ-018 pause SHALL have no effect outside SCAN.
REQ-019 A full sweep with pause held low SHALL take exactly 2**N cycles in SCAN, which is 16 for N=4.
REQ-020 On the last SCAN edge, code SHALL wrap from 2**N-1 to 0, and table[2**N-1] SHALL be captured before the wrap.
REQ-021 DONE SHALL last exactly one cycle, with done=1, and SHALL then return unconditionally to IDLE.
REQ-022 start SHALL be ignored in SCAN and DONE; it SHALL neither restart nor extend the sweep.
REQ-023 start held high continuously SHALL produce back-to-back sweeps with period 2**N+2 cycles (IDLE, SCAN x2**N, DONE).
REQ-024 table and ones SHALL hold their final values after DONE until the next accepted start clears them.
REQ-025 busy SHALL be 1 exactly when the state is SCAN, and done SHALL be 1 exactly when the state is DONE; both SHALL be registered state decodes.
REQ-026 ones SHALL never exceed 2**N, and its N+1-bit width SHALL prevent overflow.
REQ-027 When pause and the final code coincide, the block SHALL hold in SCAN and SHALL NOT transfer to DONE until pause drops.

Reset
REQ-028 On a clock edge with rst_n==0, the block SHALL enter IDLE, with code=0, table=0, ones=0, busy=0 and done=0.
REQ-029 Reset SHALL override start, pause and any in-progress sweep.
REQ-030 After a reset mid-SCAN, the partial table SHALL be discarded, and no done pulse SHALL occur.
REQ-031 With rst_n==1, the first edge after reset release SHALL behave as normal IDLE.

Verification
REQ-032 Basic sweep: connect f_in to a function that is true for minterms 2,3,4,5,6,7,10,11,12,15, pulse start -> busy for 16 cycles, a single done pulse, table=16'h9CFC, ones=10.
REQ-033 Pause: during the same sweep, assert pause for 3 cycles while code==5 -> code stays 5 for those cycles, busy stays high for 19 cycles total, and table=16'h9CFC.
REQ-034 Constant inputs: with f_in tied to 1 -> table=16'hFFFF and ones=16; with f_in tied to 0 -> table=0 and ones=0.
REQ-035 Reset mid-operation: drive rst_n low while code==9 -> on the next edge the block is in IDLE with code=0, table=0, ones=0, busy=0, and no done pulse occurs.
REQ-036 Restart rules:
  - start asserted during SCAN -> ignored; exactly one done pulse after 16 cycles;
  - start held high -> a done pulse every 18 cycles;
  - table is cleared at each accepted start.
